ajit_afb_accel_regbank: RTL and testbench

Parametrised AFB-slave register bank for the AJIT accelerator socket. It is the next generation of the fixed 16-entry accelerator register file. It adds configurable depth and base-address decode, byte-masked writes, error responses, a read-only ID register, and a doorbell/interrupt path. It sits between the AJIT core AFB request/response pipes and the accelerator datapath. ACB memory pipes are present for socket compatibility and are held idle.

---
 rtl/ajit_afb_pkg.sv | 60 ++++++
 rtl/ajit_afb_regbank_core.sv | 66 ++++++
 rtl/ajit_afb_accel_regbank.sv | 119 +++++++++++
 tb/tb_ajit_afb_accel_regbank.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ajit_afb_pkg.sv
// Shared AFB request/response layout, FSM encoding and register map for the accelerator bank.
package ajit_afb_pkg;

  localparam int unsigned AFB_REQ_W = 74;
  localparam int unsigned AFB_RSP_W = 33;
  localparam int unsigned ACB_REQ_W = 110;
  localparam int unsigned ACB_RSP_W = 65;
  localparam int unsigned ADDR_W    = 36;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned MASK_W    = 4;

  localparam int unsigned LOCK_BIT = 73;
  localparam int unsigned RW_BIT   = 72;
  localparam int unsigned MASK_HI  = 71;
  localparam int unsigned MASK_LO  = 68;
  localparam int unsigned ADDR_HI  = 67;
  localparam int unsigned ADDR_LO  = 32;
  localparam int unsigned DATA_HI  = 31;
  localparam int unsigned DATA_LO  = 0;
  localparam int unsigned ERR_BIT  = 32;

  localparam int unsigned REG_ID         = 0;
  localparam int unsigned REG_CTRL       = 1;
  localparam int unsigned REG_IRQ_STATUS = 2;
  localparam int unsigned REG_DOORBELL   = 3;
  localparam int unsigned REG_SCRATCH0   = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } afb_state_t;

  // Field order matches the bit positions above (lock is the MSB).
  typedef struct packed {
    logic              lock;
    logic              rw;
    logic [MASK_W-1:0] mask;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } afb_req_t;

  typedef struct packed {
    logic              err;
    logic [DATA_W-1:0] rdata;
  } afb_rsp_t;

  // Replace the bytes of old_v selected by mask with the matching bytes of new_v.
  function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] old_v,
                                                   input logic [DATA_W-1:0] new_v,
                                                   input logic [MASK_W-1:0] mask);
    logic [DATA_W-1:0] res;
    res = old_v;
    for (int b = 0; b < int'(MASK_W); b++) begin
      if (mask[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ajit_afb_regbank_core.sv
// Register array with byte-masked writes, doorbell/W1C pending bit and registered interrupt.
module ajit_afb_regbank_core
  import ajit_afb_pkg::*;
#(
  parameter int unsigned       NUM_REGS = 16,
  parameter logic [DATA_W-1:0] ID_VALUE = 32'hACC0_0002,
  localparam int unsigned      IDX_W    = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [MASK_W-1:0] mask,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata_c,
  output logic              irq
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic pend_q, pend_d;
  logic irq_q, irq_d;

  logic is_id_c, is_ctrl_c, is_irqs_c, is_db_c, is_storage_c, bit0_set_c;

  assign is_id_c      = (idx == IDX_W'(REG_ID));
  assign is_ctrl_c    = (idx == IDX_W'(REG_CTRL));
  assign is_irqs_c    = (idx == IDX_W'(REG_IRQ_STATUS));
  assign is_db_c      = (idx == IDX_W'(REG_DOORBELL));
  assign is_storage_c = is_ctrl_c || (32'(idx) >= REG_SCRATCH0);
  assign bit0_set_c   = mask[0] & wdata[0];

  // Next-state of storage, doorbell pending bit and interrupt.
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    if (we && is_storage_c) regs_d[idx] = byte_merge(regs_q[idx], wdata, mask);
    if (we && is_irqs_c && bit0_set_c) pend_d = 1'b0;
    if (we && is_db_c && bit0_set_c) pend_d = 1'b1;
    irq_d = pend_q & regs_q[IDX_W'(REG_CTRL)][0];
  end

  // Read mux: ID constant, pending bit, write-only doorbell, else storage.
  always_comb begin
    rdata_c = regs_q[idx];
    if (is_id_c)        rdata_c = ID_VALUE;
    else if (is_irqs_c) rdata_c = DATA_W'(pend_q);
    else if (is_db_c)   rdata_c = '0;
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '{default: '0};
      pend_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
      irq_q  <= irq_d;
    end
  end

  assign irq = irq_q;

endmodule

// File: rtl/ajit_afb_accel_regbank.sv
// AFB slave front end: request capture, address decode, IDLE/ACCESS/RESP handshake FSM.
module ajit_afb_accel_regbank
  import ajit_afb_pkg::*;
#(
  parameter int unsigned       NUM_REGS  = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 36'h0,
  parameter logic [DATA_W-1:0] ID_VALUE  = 32'hACC0_0002
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 AFB_ACCELERATOR_REQUEST_pipe_write_req,
  output logic                 AFB_ACCELERATOR_REQUEST_pipe_write_ack,
  input  logic [AFB_REQ_W-1:0] AFB_ACCELERATOR_REQUEST_pipe_write_data,
  output logic [AFB_RSP_W-1:0] AFB_ACCELERATOR_RESPONSE_pipe_read_data,
  input  logic                 AFB_ACCELERATOR_RESPONSE_pipe_read_req,
  output logic                 AFB_ACCELERATOR_RESPONSE_pipe_read_ack,
  output logic [ACB_REQ_W-1:0] ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data,
  input  logic                 ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req,
  output logic                 ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack,
  input  logic [ACB_RSP_W-1:0] ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data,
  input  logic                 ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req,
  output logic                 ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack,
  output logic                 ACCELERATOR_INTERRUPT
);

  localparam int unsigned       IDX_W    = $clog2(NUM_REGS);
  localparam int unsigned       TAG_LSB  = IDX_W + 2;
  localparam logic [ADDR_W-1:0] BASE_TAG = BASE_ADDR >> TAG_LSB;

  afb_state_t state_q, state_d;
  afb_req_t   req_q, req_d;
  afb_rsp_t   rsp_q, rsp_d;
  logic       wack_q, wack_d;
  logic       rack_q, rack_d;

  logic              hit_c;
  logic              we_c;
  logic [IDX_W-1:0]  idx_c;
  logic [DATA_W-1:0] core_rdata_c;
  logic              core_irq;

  assign hit_c = ((req_q.addr >> TAG_LSB) == BASE_TAG);
  assign idx_c = req_q.addr[IDX_W+1:2];
  assign we_c  = (state_q == ST_ACCESS) && hit_c && !req_q.rw;

  ajit_afb_regbank_core #(
    .NUM_REGS (NUM_REGS),
    .ID_VALUE (ID_VALUE)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .we      (we_c),
    .idx     (idx_c),
    .mask    (req_q.mask),
    .wdata   (req_q.wdata),
    .rdata_c (core_rdata_c),
    .irq     (core_irq)
  );

  // Next state, request capture, response load; acks follow the next state.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rsp_d   = rsp_q;
    case (state_q)
      ST_IDLE: begin
        if (AFB_ACCELERATOR_REQUEST_pipe_write_req && wack_q) begin
          req_d   = afb_req_t'(AFB_ACCELERATOR_REQUEST_pipe_write_data);
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        rsp_d.err   = !hit_c;
        rsp_d.rdata = (hit_c && req_q.rw) ? core_rdata_c : '0;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (AFB_ACCELERATOR_RESPONSE_pipe_read_req && rack_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    wack_d = (state_d == ST_IDLE);
    rack_d = (state_d == ST_RESP);
  end

  // FSM and handshake registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      rsp_q   <= '0;
      wack_q  <= 1'b0;
      rack_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rsp_q   <= rsp_d;
      wack_q  <= wack_d;
      rack_q  <= rack_d;
    end
  end

  assign AFB_ACCELERATOR_REQUEST_pipe_write_ack  = wack_q;
  assign AFB_ACCELERATOR_RESPONSE_pipe_read_data = rsp_q;
  assign AFB_ACCELERATOR_RESPONSE_pipe_read_ack  = rack_q;
  assign ACCELERATOR_INTERRUPT                   = core_irq;

  // Memory pipes are idle; stray responses are always drained.
  assign ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data   = '0;
  assign ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack    = 1'b0;
  assign ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack  = 1'b1;

  logic unused_inputs;
  assign unused_inputs = ^{ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req,
                           ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data,
                           ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req,
                           req_q.lock, req_q.addr[1:0]};

endmodule

// File: tb/tb_ajit_afb_accel_regbank.sv
// Randomised self-checking bench for ajit_afb_accel_regbank against a transaction-level model.
module tb_ajit_afb_accel_regbank;

  localparam logic [35:0] BASE = 36'h0_F000_0100;
  localparam logic [31:0] ID   = 32'hACC0_0002;

  logic         clk = 1'b0;
  logic         reset;
  logic         write_req;
  logic         write_ack;
  logic [73:0]  write_data;
  logic [32:0]  read_data;
  logic         read_req;
  logic         read_ack;
  logic [109:0] acb_req_data;
  logic         acb_req_ack;
  logic         acb_rsp_ack;
  logic         irq;

  always #5 clk = ~clk;

  ajit_afb_accel_regbank #(
    .NUM_REGS  (16),
    .BASE_ADDR (BASE),
    .ID_VALUE  (ID)
  ) dut (
    .clk                                          (clk),
    .reset                                        (reset),
    .AFB_ACCELERATOR_REQUEST_pipe_write_req       (write_req),
    .AFB_ACCELERATOR_REQUEST_pipe_write_ack       (write_ack),
    .AFB_ACCELERATOR_REQUEST_pipe_write_data      (write_data),
    .AFB_ACCELERATOR_RESPONSE_pipe_read_data      (read_data),
    .AFB_ACCELERATOR_RESPONSE_pipe_read_req       (read_req),
    .AFB_ACCELERATOR_RESPONSE_pipe_read_ack       (read_ack),
    .ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data   (acb_req_data),
    .ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req    (1'b1),
    .ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack    (acb_req_ack),
    .ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data (65'h1_2345_6789_ABCD_EF01),
    .ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req  (1'b1),
    .ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack  (acb_rsp_ack),
    .ACCELERATOR_INTERRUPT                        (irq)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Transaction-level model of the bank.
  logic [31:0] m_regs [16];
  logic        m_pend;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_pend = 1'b0;
  endtask

  task automatic model_txn(input logic rw, input logic [3:0] mask, input logic [35:0] addr,
                           input logic [31:0] wdata, output logic [32:0] rsp, output logic irq_after);
    logic hit;
    int   idx;
    hit = (addr[35:6] == BASE[35:6]);
    idx = int'(addr[5:2]);
    rsp = '0;
    if (!hit) begin
      rsp[32] = 1'b1;
    end else if (rw) begin
      case (idx)
        0:       rsp[31:0] = ID;
        2:       rsp[31:0] = {31'b0, m_pend};
        3:       rsp[31:0] = '0;
        default: rsp[31:0] = m_regs[idx];
      endcase
    end else begin
      if (idx == 1 || idx >= 4)
        for (int b = 0; b < 4; b++) if (mask[b]) m_regs[idx][8*b +: 8] = wdata[8*b +: 8];
      if (idx == 2 && mask[0] && wdata[0]) m_pend = 1'b0;
      if (idx == 3 && mask[0] && wdata[0]) m_pend = 1'b1;
    end
    irq_after = m_pend & m_regs[1][0];
  endtask

  // Expectations shared with the per-cycle compare process.
  logic        chk_on = 1'b0;
  logic        rsp_expected = 1'b0;
  logic [32:0] exp_rsp = '0;
  logic        exp_irq = 1'b0;

  always @(negedge clk) begin
    if (chk_on && !reset) begin
      check("irq", 64'(irq), 64'(exp_irq));
      if (rsp_expected) begin
        check("rack_held", 64'(read_ack), 64'd1);
        check("rdata_stable", 64'(read_data), 64'(exp_rsp));
        check("wack_in_resp", 64'(write_ack), 64'd0);
      end else begin
        check("no_stray_rack", 64'(read_ack), 64'd0);
      end
    end
  end

  // Full request/response transfer; act returns the DUT response seen at E+1.
  task automatic txn(input logic rw, input logic [3:0] mask, input logic [35:0] addr,
                     input logic [31:0] wdata, input int hold, output logic [32:0] act);
    logic [32:0] exp;
    logic        nirq;
    int          n;
    model_txn(rw, mask, addr, wdata, exp, nirq);
    n = 0;
    while (!write_ack && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!write_ack) begin
      check("wack_timeout", 64'd0, 64'd1);
      act = '0;
      return;
    end
    write_req  = 1'b1;
    write_data = {1'($urandom), rw, mask, addr, wdata};
    @(posedge clk); #1;
    write_req = 1'b0;
    check("wack_after_accept", 64'(write_ack), 64'd0);
    check("rack_in_access", 64'(read_ack), 64'd0);
    @(posedge clk); #1;
    check("rack_rise", 64'(read_ack), 64'd1);
    check("rsp_data", 64'(read_data), 64'(exp));
    act          = read_data;
    exp_rsp      = exp;
    rsp_expected = 1'b1;
    read_req     = (hold == 0);
    if (hold > 0) begin
      write_req  = 1'b1;
      write_data = {10'($urandom), 32'($urandom), 32'($urandom)};
    end
    for (int c = 1; c <= hold + 1; c++) begin
      @(posedge clk); #1;
      if (c == 1) exp_irq = nirq;
      if (c == hold) read_req = 1'b1;
    end
    rsp_expected = 1'b0;
    read_req     = 1'b0;
    write_req    = 1'b0;
    check("wack_after_xfer", 64'(write_ack), 64'd1);
  endtask

  // Write to a scratch register, then reset in ACCESS (stage 0) or RESP (stage 1).
  task automatic abort_txn(input int stage, input logic [35:0] addr);
    int n;
    n = 0;
    while (!write_ack && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    write_req  = 1'b1;
    write_data = {2'b00, 4'hF, addr, 32'hDEAD_BEEF};
    @(posedge clk); #1;
    write_req = 1'b0;
    if (stage == 1) begin
      @(posedge clk); #1;
    end
    reset        = 1'b1;
    rsp_expected = 1'b0;
    @(posedge clk); #1;
    check("rst_wack", 64'(write_ack), 64'd0);
    check("rst_rack", 64'(read_ack), 64'd0);
    check("rst_rdata", 64'(read_data), 64'd0);
    check("rst_irq", 64'(irq), 64'd0);
    model_reset();
    exp_irq = 1'b0;
    reset   = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    logic [32:0] r;
    logic [35:0] a;
    logic [3:0]  mk;
    int          sel;
    reset = 1'b1; write_req = 1'b0; read_req = 1'b0; write_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_wack", 64'(write_ack), 64'd0);
    check("reset_rack", 64'(read_ack), 64'd0);
    check("reset_rdata", 64'(read_data), 64'd0);
    check("reset_irq", 64'(irq), 64'd0);
    check("acb_req_data", 64'(acb_req_data[63:0]) | 64'(acb_req_data[109:64]), 64'd0);
    check("acb_req_ack", 64'(acb_req_ack), 64'd0);
    check("acb_rsp_ack", 64'(acb_rsp_ack), 64'd1);
    reset  = 1'b0;
    chk_on = 1'b1;

    // ID register.
    txn(1'b1, 4'h0, BASE, 32'h0, 0, r);
    check("id_read", 64'(r), 64'h0_ACC0_0002);
    txn(1'b0, 4'hF, BASE, 32'hFFFF_FFFF, 0, r);
    check("id_write_no_err", 64'(r), 64'd0);
    txn(1'b1, 4'h0, BASE + 36'h2, 32'h0, 1, r);
    check("id_unchanged", 64'(r), 64'h0_ACC0_0002);

    // Byte-masked scratch write.
    txn(1'b0, 4'b1111, BASE + 36'h10, 32'h1122_3344, 0, r);
    txn(1'b0, 4'b0101, BASE + 36'h10, 32'hAABB_CCDD, 0, r);
    txn(1'b1, 4'h0, BASE + 36'h10, 32'h0, 0, r);
    check("byte_mask", 64'(r), 64'h0_11BB_33DD);
    txn(1'b0, 4'b0000, BASE + 36'h10, 32'h0, 0, r);
    txn(1'b1, 4'h0, BASE + 36'h10, 32'h0, 0, r);
    check("mask_zero_noop", 64'(r), 64'h0_11BB_33DD);

    // Doorbell / interrupt with irq enabled.
    txn(1'b0, 4'hF, BASE + 36'h4, 32'h1, 0, r);
    txn(1'b0, 4'hF, BASE + 36'hC, 32'h1, 0, r);
    check("irq_on", 64'(irq), 64'd1);
    txn(1'b1, 4'h0, BASE + 36'h8, 32'h0, 0, r);
    check("irq_status_set", 64'(r), 64'd1);
    txn(1'b1, 4'h0, BASE + 36'hC, 32'h0, 0, r);
    check("doorbell_reads_0", 64'(r), 64'd0);
    txn(1'b0, 4'hF, BASE + 36'h8, 32'h1, 0, r);
    txn(1'b1, 4'h0, BASE + 36'h8, 32'h0, 0, r);
    check("irq_status_clr", 64'(r), 64'd0);
    check("irq_off", 64'(irq), 64'd0);

    // Doorbell with irq disabled.
    txn(1'b0, 4'hF, BASE + 36'h4, 32'h0, 0, r);
    txn(1'b0, 4'hF, BASE + 36'hC, 32'h1, 0, r);
    check("irq_masked", 64'(irq), 64'd0);
    txn(1'b1, 4'h0, BASE + 36'h8, 32'h0, 0, r);
    check("pend_masked", 64'(r), 64'd1);
    txn(1'b0, 4'hF, BASE + 36'h8, 32'h1, 0, r);

    // Out-of-range decode.
    txn(1'b1, 4'h0, BASE + 36'h40, 32'h0, 0, r);
    check("miss_read", 64'(r), 64'h1_0000_0000);
    txn(1'b0, 4'hF, BASE + 36'h40, 32'hFFFF_FFFF, 0, r);
    check("miss_write", 64'(r), 64'h1_0000_0000);
    txn(1'b1, 4'h0, BASE + 36'h10, 32'h0, 0, r);
    check("miss_no_effect", 64'(r), 64'h0_11BB_33DD);

    // Stall in RESP with a held request.
    txn(1'b1, 4'h0, BASE + 36'h10, 32'h0, 10, r);
    check("stall_data", 64'(r), 64'h0_11BB_33DD);

    // Randomised traffic.
    for (int t = 0; t < 300; t++) begin
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      a = BASE + 36'h40 + 36'({$urandom_range(0, 63), 2'b00});
      else if (sel == 1) a = {4'($urandom), 32'($urandom)};
      else               a = BASE + 36'({$urandom_range(0, 15), 2'b00}) + 36'($urandom_range(0, 3));
      mk = 4'($urandom);
      txn(1'($urandom), mk, a, $urandom, int'($urandom_range(0, 3)), r);
    end

    // Reset mid-transaction.
    txn(1'b0, 4'hF, BASE + 36'h4, 32'h1, 0, r);
    txn(1'b0, 4'hF, BASE + 36'hC, 32'h1, 0, r);
    abort_txn(0, BASE + 36'h14);
    txn(1'b1, 4'h0, BASE + 36'h14, 32'h0, 0, r);
    check("abort_access_reg", 64'(r), 64'd0);
    txn(1'b1, 4'h0, BASE + 36'h8, 32'h0, 0, r);
    check("abort_pend_cleared", 64'(r), 64'd0);
    txn(1'b0, 4'hF, BASE + 36'h18, 32'h5A5A_5A5A, 0, r);
    abort_txn(1, BASE + 36'h1C);
    txn(1'b1, 4'h0, BASE + 36'h18, 32'h0, 0, r);
    check("abort_resp_reg", 64'(r), 64'd0);
    txn(1'b1, 4'h0, BASE, 32'h0, 0, r);
    check("id_after_reset", 64'(r), 64'h0_ACC0_0002);

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
